// File: rtl/answer_frame_buffer.sv
// Collects result words until input-last plus FLUSH_CYCLES of tail, then announces and streams them.
// Announce FLUSH_CYCLES+1 cycles after input-last; o_tdata trails each ready=1 read cycle by one; ready=0 stalls reads.
module answer_frame_buffer #(
  parameter int DATA_WIDTH_IN = 32,
  parameter int NUM_WORDS     = 128,
  parameter int FLUSH_CYCLES  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH_IN-1:0] i_data,
  input  logic                     i_data_valid,
  input  logic                     i_input_last,
  input  logic                     i_tmanager_ready,
  output logic                     o_tanswer_ready,
  output logic [31:0]              o_tdata,
  output logic                     o_tdata_valid,
  output logic                     o_tanswer_data_last,
  output logic [11:0]              o_packet_size_in_bytes,
  output logic                     o_overflow
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_WORDS);

  typedef enum logic [1:0] {ST_COLLECT, ST_FLUSH, ST_ANNOUNCE, ST_SEND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
  logic [7:0]    flush_q, flush_d;
  logic          rdy_q, rdy_d, ovf_q, ovf_d, vld_q, vld_d, last_q, last_d;
  logic [11:0]   size_q, size_d;
  logic [31:0]   tdata_q;
  logic [31:0]   mem [NUM_WORDS];
  logic          wr_en, rd_en, end_flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    flush_d   = flush_q;
    rdy_d     = rdy_q;
    ovf_d     = ovf_q;
    size_d    = size_q;
    vld_d     = 1'b0;
    last_d    = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    end_flush = 1'b0;

    if (i_data_valid) begin
      if ((state_q == ST_COLLECT || state_q == ST_FLUSH) && cnt_q != FULL_CNT) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_COLLECT: begin
        if (i_input_last) begin
          if (FLUSH_CYCLES == 0) begin
            end_flush = 1'b1;
          end else begin
            state_d = ST_FLUSH;
            flush_d = 8'(FLUSH_CYCLES);
          end
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q - 8'd1;
        if (flush_q <= 8'd1) end_flush = 1'b1;
      end
      default: begin
        // ANNOUNCE and SEND share the read path; the first accepted read enters SEND
        if (i_tmanager_ready && rd_cnt_q != cnt_q) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + CW'(1);
          vld_d    = 1'b1;
          last_d   = (rd_cnt_q + CW'(1) == cnt_q);
          state_d  = ST_SEND;
        end
        if (state_q == ST_SEND && vld_q && last_q) begin
          state_d  = ST_COLLECT;
          cnt_d    = '0;
          rd_cnt_d = '0;
          rdy_d    = 1'b0;
          size_d   = '0;
          ovf_d    = 1'b0;
          vld_d    = 1'b0;
          last_d   = 1'b0;
          rd_en    = 1'b0;
        end
      end
    endcase

    if (end_flush) begin
      if (cnt_d != '0) begin
        state_d = ST_ANNOUNCE;
        rdy_d   = 1'b1;
        size_d  = 12'(cnt_d) << 2;
      end else begin
        state_d = ST_COLLECT;
        ovf_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_COLLECT;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      flush_q  <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      size_q   <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      flush_q  <= flush_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
      size_q   <= size_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

  // Word count doubles as write pointer: it restarts at 0 every frame and never passes NUM_WORDS-1 on a write
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= 32'(i_data);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      tdata_q <= '0;
    else if (rd_en) tdata_q <= mem[rd_cnt_q[AW-1:0]];
  end

  assign o_tanswer_ready        = rdy_q;
  assign o_tdata                = tdata_q;
  assign o_tdata_valid          = vld_q;
  assign o_tanswer_data_last    = last_q;
  assign o_packet_size_in_bytes = size_q;
  assign o_overflow             = ovf_q;

endmodule

// File: doc/answer_frame_buffer.md
Name: answer_frame_buffer

Overview:
Output-side frame buffer for the task pipeline. It sits directly downstream of the processing core and latency-measurement mux. It collects result words into an internal RAM until the input packet has ended and the pipeline tail has drained. It then announces the answer to the task manager with a byte count and streams the words out with a last flag under the manager's ready handshake.

Parameters:
DATA_WIDTH_IN, 32, width of incoming result words (1..32); zero-extended to 32 on output
NUM_WORDS, 128, buffer depth in words (2..1023, so NUM_WORDS*4 fits in 12 bits)
FLUSH_CYCLES, 4, cycles to keep accepting words after input-last (covers pipeline tail latency, 0..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_data  in  DATA_WIDTH_IN  result word
i_data_valid  in  1  i_data valid this cycle
i_input_last  in  1  pulse: last byte of the input packet has been accepted upstream
i_tmanager_ready  in  1  task manager accepts an answer word this cycle
o_tanswer_ready  out  1  answer available; held until the last beat
o_tdata  out  32  answer word (registered)
o_tdata_valid  out  1  o_tdata valid this cycle
o_tanswer_data_last  out  1  with final valid beat
o_packet_size_in_bytes  out  12  stored_words*4; stable while o_tanswer_ready=1
o_overflow  out  1  sticky: a word was dropped in this frame

Behaviour:
- Reset (sync, i_rst=1 at edge): state COLLECT; write/read pointers and word count = 0; all outputs 0. Reset has priority in every state, including mid-SEND. The buffer is emptied and nothing further is sent from the aborted frame.
- FSM states: COLLECT, FLUSH, ANNOUNCE, SEND.
- COLLECT:
  - Each cycle with i_data_valid=1 writes {zero-ext i_data} at wr_ptr; count increments.
  - i_input_last=1 moves to FLUSH with the flush counter loaded to FLUSH_CYCLES. A word valid in the same cycle is stored.
  - If FLUSH_CYCLES=0, go directly to the end-of-flush decision.
- FLUSH:
  - Keep storing valid words; the counter decrements each cycle.
  - At 0: if count>0, go to ANNOUNCE. If count=0, go to COLLECT; there is no answer and o_overflow is cleared.
- ANNOUNCE:
  - o_tanswer_ready=1 and o_packet_size_in_bytes=count<<2, registered on entry.
  - Move to SEND in the cycle i_tmanager_ready=1 is first seen; that cycle already reads word 0.
- SEND:
  - Every cycle with i_tmanager_ready=1 reads rd_ptr and advances it.
  - o_tdata/o_tdata_valid appear 1 cycle after the read cycle (registered RAM read).
  - i_tmanager_ready=0 stalls reads; o_tdata_valid=0 one cycle later.
  - The beat carrying word count-1 has o_tanswer_data_last=1.
  - The cycle after the last beat: o_tanswer_ready=0, o_packet_size_in_bytes=0, pointers/count=0, o_overflow cleared, state COLLECT.
- Full: a write when count=NUM_WORDS is dropped and sets o_overflow. Count and stored data are unchanged.
- Writes arriving in ANNOUNCE/SEND are dropped and set o_overflow. i_input_last outside COLLECT is ignored.
- Pointers wrap modulo NUM_WORDS but restart at 0 each frame, so no wrap occurs within a frame.
- Latency, input to announce: last stored word to o_tanswer_ready = FLUSH_CYCLES+1 cycles after i_input_last.

Test Plan:
1. Basic frame:
   - Stimulus: 5 words 0x11..0x15 with i_input_last on the 5th word, FLUSH_CYCLES=4, i_tmanager_ready held 1.
   - Response: o_tanswer_ready rises 5 cycles after last; size=20; five beats 0x11..0x15 on consecutive cycles; last with 0x15; ready drops the next cycle.
2. Flush tail:
   - Stimulus: 3 words, then i_input_last, then 2 more words within 4 cycles.
   - Response: size=20; all 5 words output in order.
3. Backpressure:
   - Stimulus: 4-word frame; i_tmanager_ready pattern 1,0,0,1,1,0,1.
   - Response: exactly 4 valid beats, in order, each 1 cycle after a ready=1 cycle; last only on the 4th; no duplicates.
4. Overflow:
   - Stimulus: NUM_WORDS=8; 10 words, then last.
   - Response: size=32; words 1..8 output; o_overflow=1 until the cycle after last beat.
5. Empty frame and late writes:
   - Stimulus: i_input_last with no words.
   - Response: no o_tanswer_ready; back in COLLECT after FLUSH.
   - Stimulus: a word during ANNOUNCE.
   - Response: word dropped; o_overflow=1.
6. Reset mid-SEND:
   - Stimulus: assert i_rst after 2 of 6 beats.
   - Response: the next cycle all outputs are 0. A following 2-word frame returns size=8 and only its own 2 words.
